hash_table_seq: RTL and testbench

Parametrised, sequential successor to the LSH hash table. It serialises insert and query of a hashed sketch over a valid/ready command interface, storing one window-ID entry per sketch element in bucketed storage. Instead of exposing a full count bus, it accumulates per-window hit counts internally and returns only the best-matching window and its count over a valid/ready result interface. It sits between the sketch/h2 hashing stage and the mapping controller.

---
 rtl/hash_table_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_hash_table_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_table_seq.sv
// hash_table_seq: sequential bucketed hash table for sketch insert / query.
// INSERT stores a window ID into the bucket named by each sketch element.
// QUERY counts hits per window internally, then reports the best window.
// Optional macro HASH_TABLE_EVICT_EN: a full bucket behaves as a circular
// buffer and overwrites its oldest entry. Without it, writes to a full bucket are dropped.
module hash_table_seq #(
  parameter int SKETCH_SIZE              = 16,
  parameter int NUM_OF_BUCKETS           = 256,
  parameter int BUCKET_SIZE              = 16,
  parameter int MAX_WINDOWS_IN_REFERENCE = 512,
  parameter int BKT_W                    = $clog2(NUM_OF_BUCKETS),
  parameter int LEN_W                    = $clog2(BUCKET_SIZE + 1),
  parameter int WIN_W                    = $clog2(MAX_WINDOWS_IN_REFERENCE),
  parameter int COUNT_W                  = $clog2(SKETCH_SIZE * BUCKET_SIZE + 1)
) (
  input  logic                         clk,
  input  logic                         reset_hash_table,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [WIN_W-1:0]             cmd_window_id,
  input  logic [SKETCH_SIZE*BKT_W-1:0] cmd_sketch,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIN_W-1:0]             res_window_id,
  output logic [COUNT_W-1:0]           res_count,
  output logic                         busy,
  output logic                         overflow
);

  localparam int IDX_W = (BUCKET_SIZE > 1) ? $clog2(BUCKET_SIZE) : 1;
  localparam int SK_W  = (SKETCH_SIZE > 1) ? $clog2(SKETCH_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSERT,
    S_GATHER,
    S_SCAN,
    S_RESULT
  } state_t;

  state_t                       state;
  logic [SK_W-1:0]              elem_idx;
  logic [LEN_W-1:0]             ent_idx;
  logic [WIN_W-1:0]             scan_id;
  logic [SKETCH_SIZE*BKT_W-1:0] sketch_reg;
  logic [WIN_W-1:0]             win_reg;

  // Bucket storage: contents are never reset, only len/wr_ptr are.
  logic [WIN_W-1:0]   bucket_mem [NUM_OF_BUCKETS][BUCKET_SIZE];
  logic [LEN_W-1:0]   len        [NUM_OF_BUCKETS];
  logic [LEN_W-1:0]   wr_ptr     [NUM_OF_BUCKETS];
  logic [COUNT_W-1:0] cnt        [MAX_WINDOWS_IN_REFERENCE];

  logic [BKT_W-1:0]   sketch_elem [SKETCH_SIZE];
  logic [BKT_W-1:0]   cur_b;
  logic [LEN_W-1:0]   cur_len;
  logic [LEN_W-1:0]   cur_wr;
  logic [LEN_W-1:0]   wr_next;
  logic               bucket_full;
  logic               store_en;
  logic               last_elem;
  logic [WIN_W-1:0]   gather_id;

  // Unpack the latched sketch into one bucket index per element.
  generate
    for (genvar gi = 0; gi < SKETCH_SIZE; gi++) begin : g_unpack
      assign sketch_elem[gi] = sketch_reg[gi*BKT_W +: BKT_W];
    end
  endgenerate

  assign cur_b       = sketch_elem[elem_idx];
  assign cur_len     = len[cur_b];
  assign cur_wr      = wr_ptr[cur_b];
  assign bucket_full = (cur_len == LEN_W'(BUCKET_SIZE));
  assign wr_next     = (cur_wr == LEN_W'(BUCKET_SIZE - 1)) ? '0 : cur_wr + 1'b1;
  assign last_elem   = (elem_idx == SK_W'(SKETCH_SIZE - 1));
  assign gather_id   = bucket_mem[cur_b][ent_idx[IDX_W-1:0]];

`ifdef HASH_TABLE_EVICT_EN
  // Full buckets overwrite the oldest entry at wr_ptr.
  assign store_en = (state == S_INSERT);
`else
  // Full buckets drop the incoming entry.
  assign store_en = (state == S_INSERT) && !bucket_full;
`endif

  // Bucket entry write during INSERT.
  always_ff @(posedge clk) begin
    if (store_en) begin
      bucket_mem[cur_b][cur_wr[IDX_W-1:0]] <= win_reg;
    end
  end

  // Command/result FSM with bucket bookkeeping and per-window hit counters.
  always_ff @(posedge clk or posedge reset_hash_table) begin
    if (reset_hash_table) begin
      state         <= S_IDLE;
      elem_idx      <= '0;
      ent_idx       <= '0;
      scan_id       <= '0;
      sketch_reg    <= '0;
      win_reg       <= '0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      res_valid     <= 1'b0;
      res_window_id <= '0;
      res_count     <= '0;
      overflow      <= 1'b0;
      for (int k = 0; k < NUM_OF_BUCKETS; k++) begin
        len[k]    <= '0;
        wr_ptr[k] <= '0;
      end
      for (int k = 0; k < MAX_WINDOWS_IN_REFERENCE; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!cmd_ready) begin
            // One-cycle recovery after CLEAR / NOP.
            cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            sketch_reg <= cmd_sketch;
            win_reg    <= cmd_window_id;
            elem_idx   <= '0;
            ent_idx    <= '0;
            cmd_ready  <= 1'b0;
            case (cmd_op)
              2'd0: begin
                state <= S_INSERT;
                busy  <= 1'b1;
              end
              2'd1: begin
                state         <= S_GATHER;
                busy          <= 1'b1;
                res_window_id <= '0;
                res_count     <= '0;
              end
              2'd2: begin
                for (int k = 0; k < NUM_OF_BUCKETS; k++) begin
                  len[k]    <= '0;
                  wr_ptr[k] <= '0;
                end
                overflow <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        S_INSERT: begin
          if (store_en) begin
            wr_ptr[cur_b] <= wr_next;
          end
          if (bucket_full) begin
            overflow <= 1'b1;
          end else begin
            len[cur_b] <= cur_len + 1'b1;
          end
          if (last_elem) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            elem_idx <= elem_idx + 1'b1;
          end
        end

        S_GATHER: begin
          if (cur_len != '0) begin
            cnt[gather_id] <= cnt[gather_id] + 1'b1;
          end
          // An empty bucket still takes one cycle.
          if ((cur_len == '0) || (ent_idx + 1'b1 == cur_len)) begin
            ent_idx <= '0;
            if (last_elem) begin
              state   <= S_SCAN;
              scan_id <= '0;
            end else begin
              elem_idx <= elem_idx + 1'b1;
            end
          end else begin
            ent_idx <= ent_idx + 1'b1;
          end
        end

        S_SCAN: begin
          // Strictly-greater replacement keeps the lowest ID on ties.
          if (cnt[scan_id] > res_count) begin
            res_count     <= cnt[scan_id];
            res_window_id <= scan_id;
          end
          cnt[scan_id] <= '0;
          if (&scan_id) begin
            state     <= S_RESULT;
            res_valid <= 1'b1;
          end else begin
            scan_id <= scan_id + 1'b1;
          end
        end

        S_RESULT: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hash_table_seq.sv
// tb_hash_table_seq: randomized self-checking bench for hash_table_seq.
// A bucket/count model computes expected results and latencies; a monitor
// checks result stability and idle status every cycle.
module tb_hash_table_seq;

  localparam int SK      = 16;
  localparam int NB      = 256;
  localparam int BS      = 16;
  localparam int NW      = 512;
  localparam int BKT_W   = 8;
  localparam int WIN_W   = 9;
  localparam int COUNT_W = 9;

  logic                  clk = 1'b0;
  logic                  reset_hash_table;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIN_W-1:0]      cmd_window_id;
  logic [SK*BKT_W-1:0]   cmd_sketch;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIN_W-1:0]      res_window_id;
  logic [COUNT_W-1:0]    res_count;
  logic                  busy;
  logic                  overflow;

  hash_table_seq #(
    .SKETCH_SIZE(SK),
    .NUM_OF_BUCKETS(NB),
    .BUCKET_SIZE(BS),
    .MAX_WINDOWS_IN_REFERENCE(NW)
  ) dut (
    .clk(clk),
    .reset_hash_table(reset_hash_table),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_window_id(cmd_window_id),
    .cmd_sketch(cmd_sketch),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_window_id(res_window_id),
    .res_count(res_count),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model of the table contents.
  int m_tab [NB][BS];
  int m_len [NB];
  int m_wr  [NB];
  bit m_ovf;

  logic [WIN_W-1:0]   exp_win = '0;
  logic [COUNT_W-1:0] exp_cnt = '0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_len[b] = 0;
      m_wr[b]  = 0;
    end
    m_ovf = 1'b0;
  endtask

  task automatic model_insert(input logic [WIN_W-1:0] w, input logic [SK*BKT_W-1:0] sk);
    for (int i = 0; i < SK; i++) begin
      int b;
      b = int'(sk[i*BKT_W +: BKT_W]);
      if (m_len[b] < BS) begin
        m_tab[b][m_wr[b]] = int'(w);
        m_wr[b]  = (m_wr[b] + 1) % BS;
        m_len[b] = m_len[b] + 1;
      end else begin
        m_ovf = 1'b1;
`ifdef HASH_TABLE_EVICT_EN
        m_tab[b][m_wr[b]] = int'(w);
        m_wr[b] = (m_wr[b] + 1) % BS;
`endif
      end
    end
  endtask

  task automatic model_query(input logic [SK*BKT_W-1:0] sk, output int bw, output int bc, output int g);
    int c [NW];
    g = 0;
    for (int i = 0; i < SK; i++) begin
      int b;
      b = int'(sk[i*BKT_W +: BKT_W]);
      for (int j = 0; j < m_len[b]; j++) c[m_tab[b][j]]++;
      g += (m_len[b] > 1) ? m_len[b] : 1;
    end
    bw = 0;
    bc = 0;
    for (int id = 0; id < NW; id++) begin
      if (c[id] > bc) begin
        bc = c[id];
        bw = id;
      end
    end
  endtask

  // Every-cycle compare: result held stable, idle status and overflow flag.
  always @(negedge clk) begin
    if (!reset_hash_table) begin
      if (res_valid) begin
        tests++;
        if (res_window_id !== exp_win || res_count !== exp_cnt) begin
          fails++;
          $display("FAIL result_hold: got id=%0d cnt=%0d, expected id=%0d cnt=%0d",
                   res_window_id, res_count, exp_win, exp_cnt);
        end
        tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL result_status: got cmd_ready=%0b busy=%0b, expected 0 1", cmd_ready, busy);
        end
      end
      if (cmd_ready) begin
        tests++;
        if (busy !== 1'b0 || overflow !== m_ovf) begin
          fails++;
          $display("FAIL idle_status: got busy=%0b overflow=%0b, expected 0 %0b", busy, overflow, m_ovf);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
  endtask

  task automatic count_low(output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One command, waited to completion; query results are captured as dw/dc.
  task automatic run_cmd(input logic [1:0] op, input logic [WIN_W-1:0] win,
                         input logic [SK*BKT_W-1:0] sk, input int hold,
                         output int mw, output int mc, output int g,
                         output int dw, output int dc);
    int cyc;
    mw = 0; mc = 0; g = 0; dw = 0; dc = 0; cyc = 0;
    wait_ready();
    if (op == 2'd1) begin
      model_query(sk, mw, mc, g);
      exp_win = WIN_W'(mw);
      exp_cnt = COUNT_W'(mc);
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_window_id = win;
    cmd_sketch = sk;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_window_id = WIN_W'($urandom);
    cmd_sketch = {$urandom, $urandom, $urandom, $urandom};
    case (op)
      2'd0: begin
        model_insert(win, sk);
        count_low(cyc);
        check("insert_ready_low", cyc, SK);
      end
      2'd2: begin
        model_reset();
        count_low(cyc);
        check("clear_ready_low", cyc, 1);
      end
      2'd3: begin
        count_low(cyc);
        check("nop_ready_low", cyc, 1);
      end
      default: begin
        while (!res_valid && cyc < 3000) begin
          @(posedge clk); #1;
          cyc++;
        end
        check("query_latency", cyc, g + NW);
        if (res_valid) begin
          dw = int'(res_window_id);
          dc = int'(res_count);
          repeat (hold) begin
            @(posedge clk); #1;
          end
          res_ready = 1'b1;
          @(posedge clk); #1;
          res_ready = 1'b0;
          check("handshake_done", int'({res_valid, cmd_ready}), 1);
        end
      end
    endcase
    $display("[TB] op=%0d win=%0d model=%0d/%0d dut=%0d/%0d cycles=%0d",
             op, win, mw, mc, dw, dc, cyc);
  endtask

  function automatic logic [SK*BKT_W-1:0] mk_sketch(input int b0, input int rest, input bit ramp);
    logic [SK*BKT_W-1:0] s;
    s = '0;
    for (int i = 0; i < SK; i++) begin
      if (i == 0) s[i*BKT_W +: BKT_W] = BKT_W'(b0);
      else s[i*BKT_W +: BKT_W] = ramp ? BKT_W'(rest + i) : BKT_W'(rest);
    end
    return s;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mw, mc, g, dw, dc;
    logic [SK*BKT_W-1:0] sk;
    logic [1:0] op;

    reset_hash_table = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_window_id = '0;
    cmd_sketch = '0;
    res_ready = 1'b0;
    model_reset();
    for (int b = 0; b < NB; b++) for (int j = 0; j < BS; j++) m_tab[b][j] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_window_id", int'(res_window_id), 0);
    check("rst_res_count", int'(res_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    reset_hash_table = 1'b0;
    @(posedge clk); #1;

    // Window 14, all-zero sketch: bucket 0 fills, bucket 1 stays empty.
    run_cmd(2'd0, 9'd14, mk_sketch(0, 0, 1'b0), 0, mw, mc, g, dw, dc);
    run_cmd(2'd1, 9'd0, mk_sketch(0, 0, 1'b0), 0, mw, mc, g, dw, dc);
    check("pin_zero_model_win", mw, 14);
    check("pin_zero_model_cnt", mc, 256);
    check("pin_zero_model_g", g, 256);
    check("pin_zero_dut_win", dw, 14);
    check("pin_zero_dut_cnt", dc, 256);
    run_cmd(2'd1, 9'd0, mk_sketch(1, 1, 1'b0), 0, mw, mc, g, dw, dc);
    check("pin_bucket1_g", g, 16);
    check("pin_bucket1_dut_cnt", dc, 0);

    // Empty table.
    run_cmd(2'd2, 9'd0, '0, 0, mw, mc, g, dw, dc);
    run_cmd(2'd1, 9'd0, mk_sketch(0, 0, 1'b1), 0, mw, mc, g, dw, dc);
    check("pin_empty_g", g, 16);
    check("pin_empty_dut_win", dw, 0);
    check("pin_empty_dut_cnt", dc, 0);

    // Tie between windows 3 and 7, lowest ID wins.
    run_cmd(2'd0, 9'd3, mk_sketch(0, 0, 1'b1), 0, mw, mc, g, dw, dc);
    run_cmd(2'd0, 9'd7, mk_sketch(0, 0, 1'b1), 0, mw, mc, g, dw, dc);
    run_cmd(2'd1, 9'd0, mk_sketch(0, 0, 1'b1), 0, mw, mc, g, dw, dc);
    check("pin_tie_model_win", mw, 3);
    check("pin_tie_model_cnt", mc, 16);
    check("pin_tie_dut_win", dw, 3);
    check("pin_tie_dut_cnt", dc, 16);

    // Overflow: bucket 5 filled by windows 20..35, then window 9.
    run_cmd(2'd2, 9'd0, '0, 0, mw, mc, g, dw, dc);
    for (int k = 0; k < 16; k++)
      run_cmd(2'd0, WIN_W'(20 + k), mk_sketch(5, 100, 1'b1), 0, mw, mc, g, dw, dc);
    check("pre_overflow_clear", int'(overflow), 0);
    run_cmd(2'd0, 9'd9, mk_sketch(5, 100, 1'b1), 0, mw, mc, g, dw, dc);
    check("overflow_set", int'(overflow), 1);
    run_cmd(2'd1, 9'd0, mk_sketch(5, 200, 1'b0), 0, mw, mc, g, dw, dc);
    check("pin_ovf_g", g, 31);
    check("pin_ovf_dut_cnt", dc, 1);
`ifdef HASH_TABLE_EVICT_EN
    check("pin_ovf_dut_win", dw, 9);
    check("pin_ovf_model_win", mw, 9);
`else
    check("pin_ovf_dut_win", dw, 20);
    check("pin_ovf_model_win", mw, 20);
`endif

    // Stall the result 10 cycles, then CLEAR and repeat.
    run_cmd(2'd1, 9'd0, mk_sketch(5, 200, 1'b0), 10, mw, mc, g, dw, dc);
    run_cmd(2'd2, 9'd0, '0, 0, mw, mc, g, dw, dc);
    run_cmd(2'd1, 9'd0, mk_sketch(5, 200, 1'b0), 0, mw, mc, g, dw, dc);
    check("pin_after_clear_cnt", dc, 0);
    check("pin_after_clear_ovf", int'(overflow), 0);

    // Randomized traffic over a small bucket and window range.
    for (int t = 0; t < 40; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      op = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      for (int i = 0; i < SK; i++) sk[i*BKT_W +: BKT_W] = BKT_W'($urandom_range(0, 7));
      run_cmd(op, WIN_W'($urandom_range(0, 15)), sk, int'($urandom_range(0, 4)),
              mw, mc, g, dw, dc);
    end

    // Reset in the middle of SCAN with counts still pending for window 400.
    sk = mk_sketch(0, 0, 1'b1);
    run_cmd(2'd0, 9'd400, sk, 0, mw, mc, g, dw, dc);
    wait_ready();
    model_query(sk, mw, mc, g);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_sketch = sk;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (g + 100) @(posedge clk);
    #2;
    reset_hash_table = 1'b1;
    model_reset();
    #1;
    check("midscan_busy", int'(busy), 0);
    check("midscan_res_valid", int'(res_valid), 0);
    check("midscan_cmd_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    reset_hash_table = 1'b0;
    $display("[TB] reset asserted mid-scan");
    run_cmd(2'd1, 9'd0, sk, 0, mw, mc, g, dw, dc);
    check("pin_post_reset_g", g, 16);
    check("pin_post_reset_cnt", dc, 0);
    check("pin_post_reset_win", dw, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
